lector_registros_picoblaze: RTL
===============================

LECTOR_REGISTROS_PICOBLAZE -- requirements
Module: lector_registros_picoblaze

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255: idle cycles allowed per byte before the transfer aborts.
REQ-002 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request a snapshot and readout; sampled in IDLE only.
REQ-005 SHALL have port read_strobe, input, 1: PicoBlaze read acknowledge of the current byte.
REQ-006 SHALL have ports in_seg_hora, in_min_hora, in_hora_hora, in_dia_fecha, in_mes_fecha, in_jahr_fecha, in_seg_timer, in_min_timer, in_hora_timer, in_banderas_config, each input, 8: register-bank outputs, BCD except the flags byte.
REQ-007 SHALL have port data_out, output, 8: current snapshot byte to the PicoBlaze input port.
REQ-008 SHALL have port index, output, 4: position 0..9 of data_out.
REQ-009 SHALL have port valid, output, 1: data_out holds an unread byte.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse on successful completion.
REQ-012 SHALL have ports bcd_err and timeout_err, each output, 1: sticky error flags.

Function
REQ-013 SHALL use states IDLE, CAPTURE, PRESENT, FINISH; all outputs registered.
REQ-014 IDLE: start=1 at edge k -> CAPTURE after edge k; start=0 -> stay in IDLE.
REQ-015 CAPTURE: at edge k+1, latch all ten inputs into a 10x8 shadow, set index=0, data_out=shadow[0], valid=1, go to PRESENT; first byte is valid 2 cycles after start.
REQ-016 Shadow order SHALL be 0 seg_hora, 1 min_hora, 2 hora_hora, 3 dia, 4 mes, 5 jahr, 6 seg_timer, 7 min_timer, 8 hora_timer, 9 banderas_config.
REQ-017 The shadow SHALL NOT change after CAPTURE; input changes during readout SHALL NOT reach data_out.
REQ-018 PRESENT with read_strobe=1 and index<9: next cycle index+1, data_out=shadow[index+1], valid stays 1, timeout counter cleared.
REQ-019 PRESENT with read_strobe=1 and index=9: go to FINISH, valid=0.
REQ-020 FINISH SHALL last one cycle, assert done=1 for that cycle only, then return to IDLE with index=0 and data_out=0.
REQ-021 PRESENT SHALL run an 8-bit timeout counter, cleared on entry and on every read_strobe; when it reaches TIMEOUT with no strobe: timeout_err=1, valid=0, go to IDLE, no done pulse.
REQ-022 At CAPTURE, bcd_err SHALL be set if any nibble of bytes 0..8 exceeds 9; byte 9 is excluded.
REQ-023 bcd_err and timeout_err SHALL clear only at the CAPTURE of the next accepted start, or on reset.
REQ-024 start while busy=1 SHALL be ignored; it neither restarts nor re-captures.
REQ-025 read_strobe while valid=0 SHALL be ignored.
REQ-026 read_strobe on the timeout cycle: the strobe wins and the byte is acknowledged.
REQ-027 start held high through FINISH SHALL begin a new transfer from IDLE on the next edge.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for a clock edge, force IDLE and set data_out=0, index=0, valid=0, busy=0, done=0, bcd_err=0, timeout_err=0, shadow=0, counter=0.
REQ-029 Reset asserted mid-transfer SHALL abort it with no done pulse; normal operation resumes on the first edge after reset=1.

Verification
REQ-030 Inputs 8'h00..8'h09 across indices 0..9, start pulse, strobe every 3rd cycle -> data_out 00..09 in order, index 0..9, one done pulse, errors 0.
REQ-031 Capture 8'h59, then change in_seg_hora to 8'h12 during readout -> byte 0 reads 8'h59.
REQ-032 in_min_hora=8'h5A, start -> bcd_err=1 after CAPTURE; next start with clean inputs -> bcd_err=0.
REQ-033 TIMEOUT=4, start, no strobes -> timeout_err=1, valid=0 and busy=0 exactly 4 cycles after valid rose; no done.
REQ-034 Second start pulse at index=3, then reset low at index=5 -> start ignored with no re-capture; after reset all outputs 0 and state IDLE.
REQ-035 in_banderas_config=8'hFF with all other bytes valid BCD -> bcd_err=0, byte 9 reads 8'hFF.

Source files
------------

// File: rtl/lector_registros_picoblaze.sv
// Snapshot of the ten clock/timer/config registers, presented one byte at a time
// to a PicoBlaze input port and advanced by its read strobe, with a per-byte timeout.
module lector_registros_picoblaze #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       read_strobe,
  input  logic [7:0] in_seg_hora,
  input  logic [7:0] in_min_hora,
  input  logic [7:0] in_hora_hora,
  input  logic [7:0] in_dia_fecha,
  input  logic [7:0] in_mes_fecha,
  input  logic [7:0] in_jahr_fecha,
  input  logic [7:0] in_seg_timer,
  input  logic [7:0] in_min_timer,
  input  logic [7:0] in_hora_timer,
  input  logic [7:0] in_banderas_config,
  output logic [7:0] data_out,
  output logic [3:0] index,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic       bcd_err,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, CAPTURE, PRESENT, FINISH} state_t;

  state_t     state, state_n;
  logic [7:0] shadow [10];
  logic [7:0] shadow_n [10];
  logic [7:0] raw [10];
  logic [7:0] cnt, cnt_n;
  logic [7:0] data_n;
  logic [3:0] index_n, next_idx;
  logic       valid_n, busy_n, done_n, bcd_n, to_n, bcd_bad;

  always_comb begin
    raw = '{in_seg_hora, in_min_hora, in_hora_hora, in_dia_fecha, in_mes_fecha,
            in_jahr_fecha, in_seg_timer, in_min_timer, in_hora_timer, in_banderas_config};
  end

  // The flags byte (position 9) is not BCD and is excluded from the check.
  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (raw[i][7:4] > 4'd9 || raw[i][3:0] > 4'd9) bcd_bad = 1'b1;
    end
  end

  assign next_idx = index + 4'd1;

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    cnt_n    = cnt;
    data_n   = data_out;
    index_n  = index;
    valid_n  = valid;
    done_n   = 1'b0;
    bcd_n    = bcd_err;
    to_n     = timeout_err;
    case (state)
      IDLE: begin
        if (start) state_n = CAPTURE;
      end
      CAPTURE: begin
        shadow_n = raw;
        cnt_n    = 8'd0;
        index_n  = 4'd0;
        data_n   = raw[0];
        valid_n  = 1'b1;
        bcd_n    = bcd_bad;
        to_n     = 1'b0;
        state_n  = PRESENT;
      end
      PRESENT: begin
        // A strobe on the same cycle the counter expires still acknowledges the byte.
        if (read_strobe) begin
          cnt_n = 8'd0;
          if (index == 4'd9) begin
            valid_n = 1'b0;
            done_n  = 1'b1;
            state_n = FINISH;
          end else begin
            index_n = next_idx;
            data_n  = shadow[next_idx];
          end
        end else if (cnt + 8'd1 == TIMEOUT) begin
          cnt_n   = 8'd0;
          to_n    = 1'b1;
          valid_n = 1'b0;
          index_n = 4'd0;
          data_n  = 8'd0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      FINISH: begin
        index_n = 4'd0;
        data_n  = 8'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shadow      <= '{default: 8'd0};
      cnt         <= 8'd0;
      data_out    <= 8'd0;
      index       <= 4'd0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      shadow      <= shadow_n;
      cnt         <= cnt_n;
      data_out    <= data_n;
      index       <= index_n;
      valid       <= valid_n;
      busy        <= busy_n;
      done        <= done_n;
      bcd_err     <= bcd_n;
      timeout_err <= to_n;
    end
  end

endmodule
